es_port_bank: RTL and testbench

- I/O responder on the CPU side of the port write strobes rwe1..rwe4 and the LES input path.
- Captures each port write (port id plus data) into a small FIFO and drains it to external devices over a valid/ready handshake.
- Holds one externally supplied input word for LES, using a valid/ack handshake toward the device side.
- The CPU cannot stall, so writes that overflow are dropped and flagged.

---
 rtl/es_port_bank_pkg.sv | 22 ++
 rtl/es_port_bank_fifo.sv | 55 +++++
 rtl/es_port_bank.sv | 140 ++++++++++++++
 tb/tb_es_port_bank.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/es_port_bank_pkg.sv
// Shared constants and input-FSM state encoding for the es_port_bank I/O responder.
package es_port_bank_pkg;

  localparam int PORT_ID_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } in_state_e;

  // Lowest-index asserted strobe wins; bit 0 is rwe1.
  function automatic logic [PORT_ID_W-1:0] lowest_port(input logic [3:0] strobes);
    logic [PORT_ID_W-1:0] id;
    id = '0;
    if (strobes[0])      id = 2'd0;
    else if (strobes[1]) id = 2'd1;
    else if (strobes[2]) id = 2'd2;
    else if (strobes[3]) id = 2'd3;
    return id;
  endfunction

endpackage

// File: rtl/es_port_bank_fifo.sv
// es_fifo: synchronous FIFO with registered head (no fall-through); a pop
// while full makes room for a simultaneous push.
module es_fifo
  import es_port_bank_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (doPop) rptr_q <= rptr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/es_port_bank.sv
// es_port_bank: CPU port-write capture FIFO, sticky overflow, and LES input holding register.
// Optional macro PORT_MIRROR_EN adds legacy parallel output latches mirror0..mirror3.
module es_port_bank
  import es_port_bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rwe1,
  input  logic                 rwe2,
  input  logic                 rwe3,
  input  logic                 rwe4,
  input  logic [DATA_W-1:0]    wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [PORT_ID_W-1:0] out_id,
  output logic                 ovf,
  input  logic                 clr_ovf,
  input  logic [DATA_W-1:0]    in_data_ext,
  input  logic                 in_valid_ext,
  output logic                 in_ack_ext,
  output logic [DATA_W-1:0]    rdata,
  input  logic                 rd_strobe,
`ifdef PORT_MIRROR_EN
  output logic [DATA_W-1:0]    mirror0,
  output logic [DATA_W-1:0]    mirror1,
  output logic [DATA_W-1:0]    mirror2,
  output logic [DATA_W-1:0]    mirror3,
`endif
  output logic                 in_full
);

  localparam int ENTRY_W = PORT_ID_W + DATA_W;

  logic [3:0]           strobes;
  logic                 wreq;
  logic [PORT_ID_W-1:0] wid;
  logic [ENTRY_W-1:0]   headEntry;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 popReq;
  logic                 ovf_q, ovf_d;
  in_state_e            state_q, state_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 ack_q, ack_d;

  assign strobes = {rwe4, rwe3, rwe2, rwe1};
  assign wreq    = |strobes;
  assign wid     = lowest_port(strobes);
  assign popReq  = out_valid && out_ready;

  es_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (wreq),
    .wdata_i ({wid, wdata}),
    .pop_i   (popReq),
    .head_o  (headEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_valid = !fifoEmpty;
  assign out_data  = headEntry[DATA_W-1:0];
  assign out_id    = headEntry[DATA_W +: PORT_ID_W];

  // A dropped write outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (wreq && fifoFull && !popReq) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

  // HELD takes only the release on rd_strobe; a new offer waits for EMPTY.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid_ext) begin
          rdata_d = in_data_ext;
          ack_d   = 1'b1;
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (rd_strobe) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign in_full    = (state_q == ST_HELD);
  assign in_ack_ext = ack_q;
  assign rdata      = rdata_q;

`ifdef PORT_MIRROR_EN
  logic [DATA_W-1:0] mirror_q [4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mirror_q[i] <= '0;
    end else if (wreq) begin
      mirror_q[wid] <= wdata;
    end
  end

  assign mirror0 = mirror_q[0];
  assign mirror1 = mirror_q[1];
  assign mirror2 = mirror_q[2];
  assign mirror3 = mirror_q[3];
`endif

endmodule

// File: tb/tb_es_port_bank.sv
// Directed and randomized checks of es_port_bank against a queue-based reference model.
// Mirror checks are compiled in when PORT_MIRROR_EN is defined.
module tb_es_port_bank;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              rwe1, rwe2, rwe3, rwe4;
  logic [DATA_W-1:0] wdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_id;
  logic              ovf;
  logic              clr_ovf;
  logic [DATA_W-1:0] in_data_ext;
  logic              in_valid_ext;
  logic              in_ack_ext;
  logic [DATA_W-1:0] rdata;
  logic              rd_strobe;
  logic              in_full;
`ifdef PORT_MIRROR_EN
  logic [DATA_W-1:0] mirror0, mirror1, mirror2, mirror3;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [1:0]        id;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            modelQ[$];
  logic              modelOvf;
  logic              modelHeld;
  logic              modelAck;
  logic [DATA_W-1:0] modelRdata;
  logic [DATA_W-1:0] modelMirror[4];

  es_port_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rwe1         (rwe1),
    .rwe2         (rwe2),
    .rwe3         (rwe3),
    .rwe4         (rwe4),
    .wdata        (wdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_id       (out_id),
    .ovf          (ovf),
    .clr_ovf      (clr_ovf),
    .in_data_ext  (in_data_ext),
    .in_valid_ext (in_valid_ext),
    .in_ack_ext   (in_ack_ext),
    .rdata        (rdata),
    .rd_strobe    (rd_strobe),
`ifdef PORT_MIRROR_EN
    .mirror0      (mirror0),
    .mirror1      (mirror1),
    .mirror2      (mirror2),
    .mirror3      (mirror3),
`endif
    .in_full      (in_full)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] strb, input logic [DATA_W-1:0] wd, input logic rdy,
                               input logic clr, input logic inV, input logic [DATA_W-1:0] inD,
                               input logic rdS);
    {rwe4, rwe3, rwe2, rwe1} = strb;
    wdata        = wd;
    out_ready    = rdy;
    clr_ovf      = clr;
    in_valid_ext = inV;
    in_data_ext  = inD;
    rd_strobe    = rdS;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf   = 1'b0;
    modelHeld  = 1'b0;
    modelAck   = 1'b0;
    modelRdata = '0;
    for (int i = 0; i < 4; i++) modelMirror[i] = '0;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelReset();
  endtask

  // Next state from the current inputs, expressed as queue and flag operations.
  task automatic modelStep();
    logic [3:0] s;
    int         pre;
    int         id;
    bit         popNow;
    bit         dropped;
    s       = {rwe4, rwe3, rwe2, rwe1};
    pre     = modelQ.size();
    popNow  = (pre > 0) && out_ready;
    dropped = 1'b0;
    if (popNow) void'(modelQ.pop_front());
    if (s != 4'b0000) begin
      id = 0;
      for (int p = 3; p >= 0; p--) if (s[p]) id = p;
      modelMirror[id] = wdata;
      if (pre < DEPTH || popNow) modelQ.push_back('{id: 2'(id), data: wdata});
      else dropped = 1'b1;
    end
    if (dropped) modelOvf = 1'b1;
    else if (clr_ovf) modelOvf = 1'b0;
    modelAck = 1'b0;
    if (!modelHeld) begin
      if (in_valid_ext) begin
        modelRdata = in_data_ext;
        modelHeld  = 1'b1;
        modelAck   = 1'b1;
      end
    end else if (rd_strobe) begin
      modelHeld = 1'b0;
    end
  endtask

  task automatic checkModel();
    checkOutput("rnd_valid", 32'(out_valid), 32'(modelQ.size() > 0));
    if (modelQ.size() > 0) begin
      checkOutput("rnd_data", 32'(out_data), 32'(modelQ[0].data));
      checkOutput("rnd_id", 32'(out_id), 32'(modelQ[0].id));
    end
    checkOutput("rnd_ovf", 32'(ovf), 32'(modelOvf));
    checkOutput("rnd_ack", 32'(in_ack_ext), 32'(modelAck));
    checkOutput("rnd_full", 32'(in_full), 32'(modelHeld));
    checkOutput("rnd_rdata", 32'(rdata), 32'(modelRdata));
`ifdef PORT_MIRROR_EN
    checkOutput("rnd_mirror0", 32'(mirror0), 32'(modelMirror[0]));
    checkOutput("rnd_mirror3", 32'(mirror3), 32'(modelMirror[3]));
`endif
  endtask

  initial begin
    logic [3:0] rs;
    // Reset state, sampled while reset is still asserted
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_ack", 32'(in_ack_ext), 32'd0);
    checkOutput("rst_full", 32'(in_full), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_id", 32'(out_id), 32'd0);
    reset = 1'b0;
    modelReset();

    // Single rwe3 write, head held stable while not ready
    applyStimulus(4'b0100, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_id", 32'(out_id), 32'd2);
      checkOutput("hold_data", 32'(out_data), 32'h5A);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("pop_single_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Overflow on the fifth write, then drain and clear
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(4'b0001, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("ovf_set", 32'(ovf), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_valid", 32'(out_valid), 32'd1);
      checkOutput("drain_data", 32'(out_data), 32'(i));
      tick();
    end
    checkOutput("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    clr_ovf   = 1'b1;
    tick();
    clr_ovf   = 1'b0;
    checkOutput("ovf_clr", 32'(ovf), 32'd0);

    // Full FIFO: push and pop together is accepted without overflow
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    applyStimulus(4'b0010, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("fullpp_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("fullpp_data", 32'(out_data), 32'(8'h10 + i));
      tick();
    end
    checkOutput("fullpp_last_data", 32'(out_data), 32'hAA);
    checkOutput("fullpp_last_id", 32'(out_id), 32'd1);
    tick();
    checkOutput("fullpp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Input holding register handshake
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
    tick();
    checkOutput("in_ack1", 32'(in_ack_ext), 32'd1);
    checkOutput("in_full1", 32'(in_full), 32'd1);
    checkOutput("in_rdata1", 32'(rdata), 32'h3C);
    in_data_ext = 8'h77;
    tick();
    checkOutput("in_noack_a", 32'(in_ack_ext), 32'd0);
    checkOutput("in_rdata_hold", 32'(rdata), 32'h3C);
    tick();
    checkOutput("in_noack_b", 32'(in_ack_ext), 32'd0);
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    checkOutput("in_release_full", 32'(in_full), 32'd0);
    checkOutput("in_release_ack", 32'(in_ack_ext), 32'd0);
    checkOutput("in_release_rdata", 32'(rdata), 32'h3C);
    tick();
    checkOutput("in_ack2", 32'(in_ack_ext), 32'd1);
    checkOutput("in_rdata2", 32'(rdata), 32'h77);
    in_valid_ext = 1'b0;
    tick();
    checkOutput("in_ack2_end", 32'(in_ack_ext), 32'd0);
    checkOutput("in_full2", 32'(in_full), 32'd1);

    // Asynchronous reset mid-cycle with two entries, overflow and a held word
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1000, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    applyStimulus(4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    checkOutput("pre_arst_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_arst_ovf", 32'(ovf), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_full", 32'(in_full), 32'd0);
    checkOutput("arst_ovf", 32'(ovf), 32'd0);
    checkOutput("arst_rdata", 32'(rdata), 32'd0);
    #2;
    reset = 1'b0;
    modelReset();
    tick();
    checkOutput("post_arst_valid", 32'(out_valid), 32'd0);

`ifdef PORT_MIRROR_EN
    // Mirror latches update even when the write is dropped
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0001, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
    end
    applyStimulus(4'b1000, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("mirror3", 32'(mirror3), 32'h99);
    checkOutput("mirror0", 32'(mirror0), 32'h33);
    checkOutput("mirror_ovf", 32'(ovf), 32'd1);
`endif

    // Randomized traffic against the reference model
    doReset();
    for (int c = 0; c < 400; c++) begin
      rs = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'b0000;
      applyStimulus(rs, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));
      modelStep();
      tick();
      checkModel();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
